// File: rtl/intcalc_pkg.sv
// intcalc_pkg: func codes, FSM state encoding and decode helpers shared by the mul/div sequencer.
package intcalc_pkg;

    localparam logic [2:0] FN_MUL  = 3'b000;
    localparam logic [2:0] FN_DIV  = 3'b001;
    localparam logic [2:0] FN_MOD  = 3'b010;
    localparam logic [2:0] FN_MULU = 3'b100;
    localparam logic [2:0] FN_DIVU = 3'b101;
    localparam logic [2:0] FN_MODU = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic is_div(logic [2:0] f);
        return f == FN_DIV || f == FN_MOD || f == FN_DIVU || f == FN_MODU;
    endfunction

    function automatic logic is_supported(logic [2:0] f);
        return f == FN_MUL || f == FN_MULU || is_div(f);
    endfunction

endpackage

// File: rtl/intcalc_seq.sv
// intcalc_seq: sequences one op at a time through the external mul/div datapath.
// Define INTCALC_SEQ_BACKTOBACK_EN to allow a new accept on the response handshake cycle.
module intcalc_seq
    import intcalc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_func,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_divzero,
    output logic             resp_badfunc,
    output logic             busy,
    output logic [2:0]       calc_func,
    output logic [WIDTH-1:0] calc_in1,
    output logic [WIDTH-1:0] calc_in2,
    input  logic [WIDTH-1:0] calc_out
);

    localparam int MAX_LAT = MUL_LATENCY > DIV_LATENCY ? MUL_LATENCY : DIV_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            accept, div_zero, bad_func, short_op;

    assign div_zero = is_div(req_func) && req_b == '0;
    assign bad_func = !is_supported(req_func);
    assign short_op = div_zero || bad_func;
    assign accept   = req_valid && req_ready;

    always_comb begin
        state_n    = state;
        resp_valid = state == S_DONE;
        busy       = state != S_IDLE;
`ifdef INTCALC_SEQ_BACKTOBACK_EN
        req_ready  = state == S_IDLE || (state == S_DONE && resp_ready);
`else
        req_ready  = state == S_IDLE;
`endif
        case (state)
            S_IDLE:  state_n = accept ? (short_op ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:   state_n = cnt == CW'(1) ? S_DONE : S_RUN;
            S_DONE:  state_n = !resp_ready ? S_DONE : accept ? (short_op ? S_DONE : S_RUN) : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt          <= '0;
            calc_func    <= FN_MUL;
            calc_in1     <= '0;
            calc_in2     <= '0;
            resp_data    <= '0;
            resp_divzero <= 1'b0;
            resp_badfunc <= 1'b0;
        end else begin
            if (accept) begin
                calc_func    <= req_func;
                calc_in1     <= req_a;
                calc_in2     <= req_b;
                cnt          <= is_div(req_func) ? CW'(DIV_LATENCY) : CW'(MUL_LATENCY);
                resp_divzero <= div_zero;
                resp_badfunc <= bad_func;
                if (short_op) resp_data <= '0;
            end else if (state == S_DONE && resp_ready) begin
                resp_divzero <= 1'b0;
                resp_badfunc <= 1'b0;
            end
            // Datapath output is only trusted once the inputs have been held for the full latency.
            if (state == S_RUN) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) resp_data <= calc_out;
            end
        end
    end

endmodule
